// File: rtl/pipe_hazard_ctl_pkg.sv
// rtl/pipe_hazard_ctl_pkg.sv - shared encodings, defaults and helpers for the hazard controller
package pipe_hazard_ctl_pkg;

  localparam int FWD_RF         = 0;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_FWD_STAGES = 3;
  localparam int DEF_MD_LAT     = 4;
  localparam int DEF_CNT_W      = 16;

  typedef struct packed {
    logic data;
    logic md_raw;
    logic md_struct;
  } stall_src_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// rtl/pipe_hazard_ctl_if.sv - decode-stage operand/writeback bundle and hazard outputs
interface pipe_hazard_ctl_if
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int REG_AW     = DEF_REG_AW,
  parameter int FWD_STAGES = DEF_FWD_STAGES,
  parameter int CNT_W      = DEF_CNT_W
) ();

  localparam int FSEL_W = clog2(FWD_STAGES + 1);

  logic [REG_AW-1:0]            rs;
  logic [REG_AW-1:0]            rt;
  logic                         use_rs;
  logic                         use_rt;
  logic                         is_md;
  logic [REG_AW-1:0]            md_dst;
  logic [FWD_STAGES-1:0]        st_wreg;
  logic [FWD_STAGES-1:0]        st_ready;
  logic [FWD_STAGES*REG_AW-1:0] st_rn;
  logic                         cnt_clr;

  logic [FSEL_W-1:0]            fwda;
  logic [FSEL_W-1:0]            fwdb;
  logic                         wpcir;
  logic                         bubble;
  logic                         md_start;
  logic                         md_busy;
  logic                         md_done;
  logic [REG_AW-1:0]            md_rn;
  logic [CNT_W-1:0]             stall_cnt;

  modport master (
    output rs, rt, use_rs, use_rt, is_md, md_dst, st_wreg, st_ready, st_rn, cnt_clr,
    input  fwda, fwdb, wpcir, bubble, md_start, md_busy, md_done, md_rn, stall_cnt
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, is_md, md_dst, st_wreg, st_ready, st_rn, cnt_clr,
    output fwda, fwdb, wpcir, bubble, md_start, md_busy, md_done, md_rn, stall_cnt
  );

endinterface

// File: rtl/pipe_fwd_sel.sv
// rtl/pipe_fwd_sel.sv - nearest-stage priority match for one source operand
module pipe_fwd_sel
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int  REG_AW     = DEF_REG_AW,
  parameter int  FWD_STAGES = DEF_FWD_STAGES,
  localparam int FSEL_W     = clog2(FWD_STAGES + 1)
) (
  input  logic [REG_AW-1:0]            operand,
  input  logic [FWD_STAGES-1:0]        st_wreg,
  input  logic [FWD_STAGES-1:0]        st_ready,
  input  logic [FWD_STAGES*REG_AW-1:0] st_rn,
  output logic [FSEL_W-1:0]            sel,
  output logic                         not_ready
);

  // Walk from the farthest stage inward so the nearest match overwrites the
  // rest; an unready near match therefore hides any ready match behind it.
  always_comb begin
    sel       = FSEL_W'(FWD_RF);
    not_ready = 1'b0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (st_wreg[k-1] &&
          (st_rn[k*REG_AW-1 -: REG_AW] != '0) &&
          (st_rn[k*REG_AW-1 -: REG_AW] == operand)) begin
        if (st_ready[k-1]) begin
          sel       = FSEL_W'(k);
          not_ready = 1'b0;
        end else begin
          sel       = FSEL_W'(FWD_RF);
          not_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// rtl/pipe_hazard_ctl.sv - forwarding selects, stall/bubble generation, mul/div tracker, stall counter
module pipe_hazard_ctl
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int REG_AW     = DEF_REG_AW,
  parameter int FWD_STAGES = DEF_FWD_STAGES,
  parameter int MD_LAT     = DEF_MD_LAT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic              clock,
  input logic              resetn,
  pipe_hazard_ctl_if.slave bus
);

  localparam int FSEL_W = clog2(FWD_STAGES + 1);
  localparam int MDC_W  = clog2(MD_LAT + 1);

  logic [FSEL_W-1:0] sel_a;
  logic [FSEL_W-1:0] sel_b;
  logic              nr_a;
  logic              nr_b;

  logic [MDC_W-1:0]  md_cnt;
  logic [REG_AW-1:0] md_rn_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              md_busy;
  logic              md_done;
  logic              stall;
  logic              md_start;
  stall_src_t        src;

  pipe_fwd_sel #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES)
  ) u_fwd_rs (
    .operand  (bus.rs),
    .st_wreg  (bus.st_wreg),
    .st_ready (bus.st_ready),
    .st_rn    (bus.st_rn),
    .sel      (sel_a),
    .not_ready(nr_a)
  );

  pipe_fwd_sel #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES)
  ) u_fwd_rt (
    .operand  (bus.rt),
    .st_wreg  (bus.st_wreg),
    .st_ready (bus.st_ready),
    .st_rn    (bus.st_rn),
    .sel      (sel_b),
    .not_ready(nr_b)
  );

  assign md_busy = (md_cnt != '0);
  assign md_done = (md_cnt == MDC_W'(1));

  // The result lands in the register file at the end of md_done, so a
  // dependent waits through that cycle and then reads the file directly.
  always_comb begin
    src           = '0;
    src.data      = (bus.use_rs && nr_a) || (bus.use_rt && nr_b);
    src.md_raw    = md_busy && (md_rn_q != '0) &&
                    ((bus.use_rs && (bus.rs == md_rn_q)) ||
                     (bus.use_rt && (bus.rt == md_rn_q)));
    src.md_struct = bus.is_md && md_busy && !md_done;
  end

  assign stall    = src.data || src.md_raw || src.md_struct;
  assign md_start = bus.is_md && !stall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      md_cnt  <= '0;
      md_rn_q <= '0;
    end else if (md_start) begin
      md_cnt  <= MDC_W'(MD_LAT);
      md_rn_q <= bus.md_dst;
    end else if (md_cnt != '0) begin
      md_cnt  <= md_cnt - MDC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stall && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwda      = sel_a;
  assign bus.fwdb      = sel_b;
  assign bus.wpcir     = !stall;
  assign bus.bubble    = stall;
  assign bus.md_start  = md_start;
  assign bus.md_busy   = md_busy;
  assign bus.md_done   = md_done;
  assign bus.md_rn     = md_rn_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
